// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file and its arbiter.
// The CPU top reuses the requester indices and default widths.
package regfile_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int RF_SIZE_DEF = 4;
  localparam int NUM_REQ_MAX = 4;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_LOCK  = 2'd2
  } state_e;

endpackage

// File: rtl/regfile_bank.sv
// Register storage: two async read ports, one sync write port.
// Async reset clears every register.
module regfile_bank
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_SIZE_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter with bounded lock in front of the register file.
// One access (two reads, optional write) per granted cycle.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int RF_SIZE  = RF_SIZE_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOCK_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          lock,
  input  logic [NUM_REQ-1:0]          we,
  input  logic [NUM_REQ*RF_SIZE-1:0]  ra,
  input  logic [NUM_REQ*RF_SIZE-1:0]  rb,
  input  logic [NUM_REQ*RF_SIZE-1:0]  rd,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DATA_W-1:0]           rdata_a,
  output logic [DATA_W-1:0]           rdata_b,
  output logic [NUM_REQ-1:0]          rvalid
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX) + 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0]  rdata_b_q, rdata_b_d;

  logic               active;
  logic               bank_we;
  logic [RF_SIZE-1:0] own_ra, own_rb, own_rd;
  logic [DATA_W-1:0]  own_wdata;
  logic [DATA_W-1:0]  bank_a, bank_b;
  logic [IDX_W-1:0]   win;
  logic               keep;

  // Lowest offset from start wins; start is always last owner + 1.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_REQ-1:0] r,
    input logic [IDX_W-1:0]   start
  );
    logic [IDX_W-1:0] pick;
    int idx;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (r[idx]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] i
  );
    return IDX_W'((int'(i) + 1) % NUM_REQ);
  endfunction

  assign active    = (state_q != S_IDLE);
  assign own_ra    = ra[owner_q*RF_SIZE +: RF_SIZE];
  assign own_rb    = rb[owner_q*RF_SIZE +: RF_SIZE];
  assign own_rd    = rd[owner_q*RF_SIZE +: RF_SIZE];
  assign own_wdata = wdata[owner_q*DATA_W +: DATA_W];
  assign bank_we   = active & we[owner_q];

  regfile_bank #(
    .ADDR_W (RF_SIZE),
    .DATA_W (DATA_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (bank_we),
    .waddr   (own_rd),
    .wdata   (own_wdata),
    .raddr_a (own_ra),
    .raddr_b (own_rb),
    .rdata_a (bank_a),
    .rdata_b (bank_b)
  );

  assign win  = rr_pick(req, ptr_q);
  assign keep = lock[owner_q] && (int'(cnt_q) < LOCK_MAX - 1);

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    rvalid_d  = gnt_q;
    rdata_a_d = active ? bank_a : '0;
    rdata_b_d = active ? bank_b : '0;
    unique case (state_q)
      S_GRANT, S_LOCK: begin
        if (keep) begin
          state_d = S_LOCK;
          cnt_d   = cnt_q + 1'b1;
          gnt_d   = gnt_q;
        end else begin
          cnt_d = '0;
          if (|req) begin
            state_d = S_GRANT;
            owner_d = win;
            ptr_d   = nxt(win);
            gnt_d   = NUM_REQ'(1) << win;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d = '0;
        if (|req) begin
          state_d = S_GRANT;
          owner_d = win;
          ptr_d   = nxt(win);
          gnt_d   = NUM_REQ'(1) << win;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      rvalid_q  <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      rvalid_q  <= rvalid_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  assign gnt     = gnt_q;
  assign rvalid  = rvalid_q;
  assign rdata_a = rdata_a_q;
  assign rdata_b = rdata_b_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: reset, access, round-robin,
// lock bound, read-during-write and reset during a locked access.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, lock, we;
  logic [7:0]  ra, rb, rd;
  logic [15:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [7:0]  rdata_a, rdata_b;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .lock    (lock),
    .we      (we),
    .ra      (ra),
    .rb      (rb),
    .rd      (rd),
    .wdata   (wdata),
    .gnt     (gnt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .rvalid  (rvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_in();
    req = '0; lock = '0; we = '0;
    ra = '0; rb = '0; rd = '0; wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clr_in();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One access by requester idx; returns grant latency and read data.
  task automatic do_acc(input int idx, input logic [3:0] a,
                        input logic [3:0] b, input logic w,
                        input logic [3:0] d, input logic [7:0] wd,
                        output int lat, output logic [7:0] ga,
                        output logic [7:0] gb);
    ra[idx*4 +: 4]    = a;
    rb[idx*4 +: 4]    = b;
    rd[idx*4 +: 4]    = d;
    wdata[idx*8 +: 8] = wd;
    we[idx]           = w;
    req[idx]          = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!gnt[idx] && lat < 20);
    chk("grant_wait", 32'(gnt[idx]), 32'd1);
    req[idx] = 1'b0;
    @(negedge clk);
    chk("rvalid", 32'(rvalid), 32'(2'b01 << idx));
    ga = rdata_a;
    gb = rdata_b;
    we[idx] = 1'b0;
  endtask

  int         lat;
  logic [7:0] ga, gb;
  logic [1:0] exp_gnt [6];

  initial begin
    rst = 1'b0;
    req = 2'($urandom); lock = 2'($urandom); we = 2'($urandom);
    ra = 8'($urandom); rb = 8'($urandom); rd = 8'($urandom);
    wdata = 16'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata_a", 32'(rdata_a), 32'd0);
    chk("rst_rdata_b", 32'(rdata_b), 32'd0);
    clr_in();
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_acc(1, 4'(i), 4'(i + 8), 1'b0, 4'd0, 8'd0, lat, ga, gb);
      chk("clr_read_a", 32'(ga), 32'd0);
      chk("clr_read_b", 32'(gb), 32'd0);
    end

    do_acc(0, 4'd0, 4'd0, 1'b1, 4'd3, 8'h2A, lat, ga, gb);
    chk("wr_latency", 32'(lat), 32'd1);
    do_acc(0, 4'd3, 4'd0, 1'b0, 4'd0, 8'd0, lat, ga, gb);
    chk("rd_r3", 32'(ga), 32'h2A);

    do_acc(0, 4'd0, 4'd0, 1'b1, 4'd5, 8'h11, lat, ga, gb);
    do_acc(0, 4'd5, 4'd3, 1'b1, 4'd5, 8'h99, lat, ga, gb);
    chk("rdw_old", 32'(ga), 32'h11);
    chk("rdw_b", 32'(gb), 32'h2A);
    do_acc(1, 4'd5, 4'd5, 1'b0, 4'd0, 8'd0, lat, ga, gb);
    chk("rdw_new", 32'(ga), 32'h99);

    // Round-robin with a write by 0 seen by 1 in the next cycle.
    do_reset();
    ra[3:0] = 4'd9; rd[3:0] = 4'd9; wdata[7:0] = 8'h5A; we[0] = 1'b1;
    ra[7:4] = 4'd9;
    req = 2'b11;
    @(negedge clk);
    chk("rr_g1", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("rr_g2", 32'(gnt), 32'h2);
    chk("rr_v2", 32'(rvalid), 32'h1);
    chk("rr_old9", 32'(rdata_a), 32'h00);
    @(negedge clk);
    chk("rr_g3", 32'(gnt), 32'h1);
    chk("rr_v3", 32'(rvalid), 32'h2);
    chk("rr_new9", 32'(rdata_a), 32'h5A);
    @(negedge clk);
    chk("rr_g4", 32'(gnt), 32'h2);
    clr_in();

    do_reset();
    exp_gnt = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    req = 2'b11;
    lock = 2'b01;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("lock_g%0d", i), 32'(gnt), 32'(exp_gnt[i]));
    end
    clr_in();

    do_reset();
    req[0] = 1'b1; lock[0] = 1'b1; we[0] = 1'b1;
    rd[3:0] = 4'd7; wdata[7:0] = 8'hFF;
    @(negedge clk);
    chk("ml_g1", 32'(gnt), 32'h1);
    @(negedge clk);
    chk("ml_g2", 32'(gnt), 32'h1);
    rst = 1'b0;
    #1;
    chk("ml_gnt", 32'(gnt), 32'd0);
    chk("ml_rvalid", 32'(rvalid), 32'd0);
    chk("ml_rdata", 32'(rdata_a), 32'd0);
    clr_in();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ml_idle", 32'(gnt), 32'd0);
    do_acc(1, 4'd7, 4'd7, 1'b0, 4'd0, 8'd0, lat, ga, gb);
    chk("ml_r7", 32'(ga), 32'd0);
    chk("ml_lat", 32'(lat), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
